rg_field_issue: RTL and testbench
=================================

Name: rg_field_issue

Overview:
- Parametrised successor to the fixed RG1/RG2 register-field extractors.
- Holds one instruction word in a single-entry decode stage. Extracts the two register-address fields at parametrised bit positions.
- Tracks outstanding register writes in a scoreboard. Stalls issue on any read-after-write or write-after-write hazard.
- Sits between the instruction register (MIDR) and register-file/ALU issue. Writeback retires scoreboard entries.

Parameters:
INSTR_W, 16, instruction word width
REG_W, 5, register address width; NUM_REGS = 2**REG_W
RG1_LSB, 7, LSB of RG1 field (field = instr[RG1_LSB+REG_W-1:RG1_LSB])
RG2_LSB, 2, LSB of RG2 field
ZERO_REG_HARDWIRED, 1, when 1 register 0 is never marked pending

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of held instruction and all pending bits
instr_in  input  INSTR_W  instruction word (MIDR_out)
instr_wr  input  1  instruction writes register RG1
instr_valid  input  1  instr_in/instr_wr valid
instr_ready  output  1  stage can accept this cycle
rg1_out  output  REG_W  RG1 field of held instruction
rg2_out  output  REG_W  RG2 field of held instruction
wr_out  output  1  held instruction's write flag
out_valid  output  1  held instruction issuable
out_ready  input  1  downstream accepts
hazard  output  1  held instruction blocked by scoreboard
wb_valid  input  1  writeback retire strobe
wb_addr  input  REG_W  register being retired
pending  output  NUM_REGS  scoreboard bit per register

Behaviour:
- Reset (async, rst=1): held_valid=0, rg1_out=0, rg2_out=0, wr_out=0, pending=0. Hence out_valid=0, hazard=0, instr_ready=1.
- Field extraction: rg1/rg2 are registered on accept, not combinational from instr_in. They are stable while held.
- hazard = held_valid & (pending[rg1_out] | pending[rg2_out]). It uses registered pending only; there is no same-cycle writeback bypass.
- out_valid = held_valid & ~hazard (combinational).
- issue = out_valid & out_ready.
- instr_ready = ~held_valid | issue (combinational). Back-to-back issue is 1 per cycle.
- Accept = instr_valid & instr_ready. On the next edge: held_valid=1, fields and wr_out are loaded. Latency is 1 cycle from accept to out_valid, absent a hazard.
- Issue without accept: held_valid clears. Issue with accept: the new instruction replaces the old one in the same edge.
- Scoreboard, each edge:
  - issue & wr_out sets pending[rg1_out], unless ZERO_REG_HARDWIRED and rg1_out=0.
  - wb_valid clears pending[wb_addr].
  - Same register set and cleared in one cycle: set wins (new writer outstanding).
  - wb_valid for a non-pending register: no effect.
- Held instruction with hazard: stays held and fields are unchanged. out_valid re-asserts the cycle after the blocking bit clears.
- Self-dependency: rg1_out=rg2_out is legal and checks one bit.
- flush (synchronous, highest priority over accept/issue/wb): held_valid=0 and pending=0 on the next edge. Outputs are cleared as at reset.
- rst asserted mid-operation: immediate clear, regardless of clock.
- pending[0] is constant 0 when ZERO_REG_HARDWIRED=1.

Test Plan:
- Reset then accept instr_in=16'h0A84, instr_wr=1 with out_ready=1.
  -> Next cycle rg1_out=21, rg2_out=1, out_valid=1. The following cycle pending[21]=1.
- Then accept 16'h0104 (rg1=2, rg2=1) followed by 16'h0854 (rg1=16, rg2=21).
  -> First issues. Second holds with hazard=1, out_valid=0, instr_ready=0.
  -> wb_valid=1, wb_addr=21 gives out_valid=1 exactly one cycle later.
- Issue a writer to reg 5 in the same cycle as wb_valid, wb_addr=5 (with pending[5]=1).
  -> pending[5] stays 1.
- Instruction with rg1=0, instr_wr=1, ZERO_REG_HARDWIRED=1.
  -> pending stays 0, no later hazard on reg 0.
- Continuous stream of 4 independent instructions with out_ready=1.
  -> One issue per cycle and instr_ready held at 1.
- Assert flush while holding a hazarded instruction with pending=32'h0020_0004.
  -> Next cycle pending=0, out_valid=0, instr_ready=1.
- Pulse rst mid-stream between clock edges.
  -> All outputs clear before the next edge.

Source files
------------

// File: rtl/rg_field_issue.sv
// Single-entry decode/issue stage: extracts RG1/RG2 from the held instruction and
// stalls issue on RAW/WAW hazards tracked by a per-register pending scoreboard.
module rg_field_issue #(
    parameter int INSTR_W            = 16,
    parameter int REG_W              = 5,
    parameter int RG1_LSB            = 7,
    parameter int RG2_LSB            = 2,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [INSTR_W-1:0]    instr_in,
    input  logic                  instr_wr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [REG_W-1:0]      rg1_out,
    output logic [REG_W-1:0]      rg2_out,
    output logic                  wr_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  hazard,
    input  logic                  wb_valid,
    input  logic [REG_W-1:0]      wb_addr,
    output logic [2**REG_W-1:0]   pending
);

    localparam int NUM_REGS = 2**REG_W;
    localparam bit ZERO_HW  = (ZERO_REG_HARDWIRED != 0);

    logic                held_valid_reg;
    logic [REG_W-1:0]    rg1_reg;
    logic [REG_W-1:0]    rg2_reg;
    logic                wr_reg;
    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;

    logic hazard_int;
    logic out_valid_int;
    logic issue;
    logic accept;
    logic set_en;
    logic rg1_is_zero;

    // Only the two register fields of the instruction word are consumed here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in;

    assign hazard_int    = held_valid_reg & (pending_reg[rg1_reg] | pending_reg[rg2_reg]);
    assign out_valid_int = held_valid_reg & ~hazard_int;
    assign issue         = out_valid_int & out_ready;
    assign instr_ready   = ~held_valid_reg | issue;
    assign accept        = instr_valid & instr_ready;

    assign rg1_is_zero = (rg1_reg == '0);
    assign set_en      = issue & wr_reg & ~(ZERO_HW & rg1_is_zero);

    // Per-register next state: a new writer's set overrides a same-cycle retire.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (ZERO_HW && gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_reg
                assign pending_next[gi] =
                    (set_en && (rg1_reg == REG_W'(gi))) ||
                    (pending_reg[gi] && !(wb_valid && (wb_addr == REG_W'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_valid_reg <= 1'b0;
            rg1_reg        <= '0;
            rg2_reg        <= '0;
            wr_reg         <= 1'b0;
            pending_reg    <= '0;
        end else if (flush) begin
            held_valid_reg <= 1'b0;
            rg1_reg        <= '0;
            rg2_reg        <= '0;
            wr_reg         <= 1'b0;
            pending_reg    <= '0;
        end else begin
            pending_reg <= pending_next;
            if (accept) begin
                held_valid_reg <= 1'b1;
                rg1_reg        <= instr_in[RG1_LSB +: REG_W];
                rg2_reg        <= instr_in[RG2_LSB +: REG_W];
                wr_reg         <= instr_wr;
            end else if (issue) begin
                held_valid_reg <= 1'b0;
            end
        end
    end

    assign rg1_out   = rg1_reg;
    assign rg2_out   = rg2_reg;
    assign wr_out    = wr_reg;
    assign out_valid = out_valid_int;
    assign hazard    = hazard_int;
    assign pending   = pending_reg;

endmodule

// File: tb/tb_rg_field_issue.sv
// Bench for rg_field_issue: directed scenarios plus random traffic, all checked
// against a cycle-level model of the held instruction and scoreboard.
module tb_rg_field_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] instr_in;
    logic        instr_wr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rg1_out;
    logic [4:0]  rg2_out;
    logic        wr_out;
    logic        out_valid;
    logic        out_ready;
    logic        hazard;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [45:0] RESET_VEC = 46'h2000_0000_0000;

    rg_field_issue #(
        .INSTR_W(16), .REG_W(5), .RG1_LSB(7), .RG2_LSB(2), .ZERO_REG_HARDWIRED(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .instr_in(instr_in), .instr_wr(instr_wr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rg1_out(rg1_out), .rg2_out(rg2_out),
        .wr_out(wr_out), .out_valid(out_valid), .out_ready(out_ready),
        .hazard(hazard), .wb_valid(wb_valid), .wb_addr(wb_addr), .pending(pending)
    );

    always #5 clk = ~clk;

    wire [45:0] dut_vec = {instr_ready, out_valid, hazard, wr_out, rg1_out, rg2_out, pending};

    // Reference model: the held instruction as plain fields, the scoreboard as a bit set.
    bit        m_held;
    bit        m_wr;
    bit [4:0]  m_rg1;
    bit [4:0]  m_rg2;
    bit [31:0] m_pend;

    function automatic void model_clear();
        m_held = 0; m_wr = 0; m_rg1 = 0; m_rg2 = 0; m_pend = 0;
    endfunction

    function automatic bit m_hazard();
        return m_held && (m_pend[m_rg1] || m_pend[m_rg2]);
    endfunction

    function automatic bit [45:0] exp_vec();
        bit ov;
        bit ir;
        ov = m_held && !m_hazard();
        ir = !m_held || (ov && out_ready);
        return {ir, ov, m_hazard(), m_wr, m_rg1, m_rg2, m_pend};
    endfunction

    // Drive one clock of inputs (from a falling edge), advance the model, return at the next falling edge.
    task automatic cycle(input bit iv, input bit [15:0] ins, input bit wr, input bit ordy,
                         input bit wbv, input bit [4:0] wba, input bit fl);
        bit        iss;
        bit        acc;
        bit [31:0] np;
        instr_valid = iv; instr_in = ins; instr_wr = wr; out_ready = ordy;
        wb_valid = wbv; wb_addr = wba; flush = fl;
        iss = m_held && !m_hazard() && ordy;
        acc = iv && (!m_held || iss);
        np  = m_pend;
        if (wbv) np[wba] = 1'b0;
        if (iss && m_wr && m_rg1 != 5'd0) np[m_rg1] = 1'b1;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            m_pend = np;
            if (acc) begin
                m_held = 1; m_rg1 = ins[11:7]; m_rg2 = ins[6:2]; m_wr = wr;
            end else if (iss) begin
                m_held = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 16'h0, 0, 1, 0, 5'd0, 0);
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; instr_in = 0; instr_wr = 0; instr_valid = 0;
        out_ready = 0; wb_valid = 0; wb_addr = 0;
        model_clear();
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_held: got %h want %h", dut_vec, RESET_VEC);
        end
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_release: got %h want %h", dut_vec, RESET_VEC);
        end
        $display("reset: outputs %h", dut_vec);
    endtask

    task automatic test_basic_issue();
        cycle(1, 16'h0A84, 1, 1, 0, 5'd0, 0);
        n_checks++;
        if (rg1_out !== 5'd21 || rg2_out !== 5'd1 || out_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL basic_accept: got rg1=%0d rg2=%0d ov=%b want rg1=21 rg2=1 ov=1", rg1_out, rg2_out, out_valid);
        end
        idle();
        n_checks++;
        if (pending[21] !== 1'b1 || out_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL basic_pending21: got pending=%h want %h", pending, 32'h0020_0000);
        end
        $display("basic_issue: rg1=%0d rg2=%0d pending=%h", rg1_out, rg2_out, pending);
    endtask

    task automatic test_hazard();
        cycle(1, 16'h0104, 1, 1, 0, 5'd0, 0);
        n_checks++;
        if (out_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL hazard_first: got ov=%b want 1", out_valid);
        end
        cycle(1, 16'h0854, 1, 1, 0, 5'd0, 0);
        n_checks++;
        if (hazard !== 1'b1 || out_valid !== 1'b0 || instr_ready !== 1'b0 ||
            pending !== 32'h0020_0004 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL hazard_hold: got hz=%b ov=%b ir=%b pend=%h want 1 0 0 00200004", hazard, out_valid, instr_ready, pending);
        end
        cycle(0, 16'h0, 0, 1, 1, 5'd21, 0);
        n_checks++;
        if (out_valid !== 1'b1 || hazard !== 1'b0 || rg1_out !== 5'd16 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL hazard_release: got ov=%b hz=%b rg1=%0d want 1 0 16", out_valid, hazard, rg1_out);
        end
        idle();
        n_checks++;
        if (pending !== 32'h0001_0004 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL hazard_drain: got pending=%h want 00010004", pending);
        end
        $display("hazard: pending=%h", pending);
    endtask

    task automatic test_set_wins();
        cycle(1, 16'h0280, 1, 1, 0, 5'd0, 0);
        cycle(0, 16'h0, 0, 1, 1, 5'd5, 0);
        n_checks++;
        if (pending[5] !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL set_wins: got pending[5]=%b want 1", pending[5]);
        end
        cycle(0, 16'h0, 0, 1, 1, 5'd5, 0);
        n_checks++;
        if (pending[5] !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL wb_clear5: got pending[5]=%b want 0", pending[5]);
        end
        cycle(0, 16'h0, 0, 1, 1, 5'd9, 0);
        n_checks++;
        if (pending !== 32'h0001_0004 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL wb_nonpending: got pending=%h want 00010004", pending);
        end
        $display("set_wins: pending=%h", pending);
    endtask

    task automatic test_zero_reg();
        cycle(1, 16'h0000, 1, 1, 0, 5'd0, 0);
        cycle(1, 16'h0180, 0, 1, 0, 5'd0, 0);
        n_checks++;
        if (pending[0] !== 1'b0 || out_valid !== 1'b1 || hazard !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL zero_reg: got pending[0]=%b ov=%b hz=%b want 0 1 0", pending[0], out_valid, hazard);
        end
        idle();
        $display("zero_reg: pending=%h", pending);
    endtask

    task automatic test_back_to_back();
        cycle(0, 16'h0, 0, 1, 0, 5'd0, 1);
        n_checks++;
        if (pending !== 32'h0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL b2b_flush: got pending=%h want 0", pending);
        end
        for (int i = 0; i < 4; i++) begin
            bit [15:0] ins;
            ins = {4'b0, 5'(10 + i), 5'(20 + i), 2'b0};
            cycle(1, ins, 1, 1, 0, 5'd0, 0);
            n_checks++;
            if (instr_ready !== 1'b1 || out_valid !== 1'b1 || rg1_out !== 5'(10 + i) || dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_%0d: got ir=%b ov=%b rg1=%0d want 1 1 %0d", i, instr_ready, out_valid, rg1_out, 10 + i);
            end
            $display("b2b %0d: rg1=%0d rg2=%0d pending=%h", i, rg1_out, rg2_out, pending);
        end
        idle();
    endtask

    task automatic test_flush();
        cycle(0, 16'h0, 0, 1, 0, 5'd0, 1);
        cycle(1, 16'h0A80, 1, 1, 0, 5'd0, 0);
        cycle(1, 16'h0100, 1, 1, 0, 5'd0, 0);
        cycle(1, 16'h0854, 1, 1, 0, 5'd0, 0);
        n_checks++;
        if (pending !== 32'h0020_0004 || hazard !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL flush_setup: got pending=%h hz=%b want 00200004 1", pending, hazard);
        end
        cycle(0, 16'h0, 0, 1, 0, 5'd0, 1);
        n_checks++;
        if (pending !== 32'h0 || out_valid !== 1'b0 || instr_ready !== 1'b1 || dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL flush: got %h want %h", dut_vec, RESET_VEC);
        end
        $display("flush: outputs %h", dut_vec);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            bit        iv;
            bit        wr;
            bit        ordy;
            bit        wbv;
            bit        fl;
            bit [4:0]  wba;
            bit [15:0] ins;
            int        start;
            iv   = ($urandom_range(0, 3) != 0);
            wr   = $urandom_range(0, 1);
            ordy = ($urandom_range(0, 3) != 0);
            wbv  = $urandom_range(0, 1);
            fl   = ($urandom_range(0, 63) == 0);
            ins  = 16'($urandom);
            wba  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    if (m_pend[(start + k) % 32]) begin
                        wba = 5'((start + k) % 32);
                        break;
                    end
                end
            end
            cycle(iv, ins, wr, ordy, wbv, wba, fl);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; errs++;
                $display("FAIL random_%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        $display("random: 400 cycles, %0d differences", errs);
    endtask

    task automatic test_async_reset();
        cycle(0, 16'h0, 0, 1, 0, 5'd0, 1);
        cycle(1, 16'h0A84, 1, 1, 0, 5'd0, 0);
        cycle(1, 16'h0104, 1, 0, 0, 5'd0, 0);
        #2 rst = 1;
        #1;
        model_clear();
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", dut_vec, RESET_VEC);
        end
        instr_valid = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL async_release: got %h want %h", dut_vec, exp_vec());
        end
        $display("async_reset: outputs %h", dut_vec);
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_hazard();
        test_set_wins();
        test_zero_reg();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
